load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: sits between the core's MEM stage and data_mem.
//  Turns core load/store requests (byte/half/word, signed/unsigned) into word-addressed memory
//  requests with byte enables. Stalls the core until the memory response arrives.
//  Checks alignment, sign/zero-extends load data and reports faults (misaligned, illegal size, timeout).
// PARAMETERS
//  TIMEOUT    16   max BUSY cycles waiting for mem_ready_i before abort with fault (>=2)
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  rst_ni           in   1   reset, asynchronous, active-low
//  core_req_i       in   1   core requests a memory access this cycle
//  core_we_i        in   1   1 = store, 0 = load
//  core_size_i      in   3   funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
//  core_addr_i      in   32  byte address
//  core_wd_i        in   32  store data, right-aligned
//  core_rd_o        out  32  load result, extended; valid in completion cycle
//  core_stall_o     out  1   core must hold all core_* inputs and not advance
//  access_fault_o   out  1   one-cycle pulse: misaligned, illegal size or timeout
//  mem_req_o        out  1   memory request
//  mem_we_o         out  1   memory write enable
//  mem_be_o         out  4   byte enables (bit i = byte lane i)
//  mem_addr_o       out  32  {addr[31:2],2'b00}
//  mem_wd_o         out  32  lane-replicated store data
//  mem_rd_i         in   32  memory read word
//  mem_ready_i      in   1   memory response valid (load data valid / store committed)
// BEHAVIOUR
//  - FSM: IDLE, BUSY. Reset: state=IDLE, counter=0, latched request regs=0; all outputs 0.
//  - IDLE, core_req_i=1, legal+aligned: mem_* driven combinationally from core_* inputs, core_stall_o=1,
//    latch we/size/addr/wd, -> BUSY. Counter cleared.
//  - IDLE, core_req_i=1, misaligned (H/HU addr[0]=1; W addr[1:0]!=0) or illegal size (011,110,111,
//    or store with size[2]=1): mem_req_o=0, core_stall_o=0, access_fault_o=1 same cycle, stay IDLE.
//  - BUSY: mem_* driven from latched regs (inputs ignored). Counter +1 per cycle.
//    mem_ready_i=1: core_stall_o=0, core_rd_o = extended mem_rd_i (loads; 0 for stores), -> IDLE.
//    counter==TIMEOUT-1 and mem_ready_i=0: core_stall_o=0, access_fault_o=1, core_rd_o=32'hdead_beef, -> IDLE.
//  - mem_ready_i seen in IDLE is ignored. Minimum access = 2 cycles (request, completion); data_mem
//    latency 1 gives exactly 2. Next request accepted the cycle after completion.
//  - Store lanes: B be=4'b0001<<addr[1:0], wd={4{wd[7:0]}}; H be=addr[1]?4'b1100:4'b0011,
//    wd={2{wd[15:0]}}; W be=4'b1111, wd=wd.
//  - Load extract from latched addr[1:0]: B/BU byte lane addr[1:0]; H/HU half lane addr[1];
//    B,H sign-extend; BU,HU zero-extend; W passthrough.
//  - core_rd_o=0 and access_fault_o=0 in all cycles other than completion/fault cycles.
//  - Async reset mid-BUSY: mem_req_o and core_stall_o drop immediately; in-flight access abandoned.
//  - core_req_i deasserted while BUSY: ignored, access completes from latched regs.
// STRUCTURE
//  - riscv_pkg: LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5; lsu_state_t enum.
//  - Sub-module lsu_load_ext: combinational lane select + extension (rd word, offset, size -> result).
//  - Counter width $clog2(TIMEOUT)+1.
// TESTING
//  1 SW addr=0x10 wd=0xCAFEBABE, ready next cycle -> mem_be_o=1111, mem_addr_o=0x10, stall 1 then 0.
//  2 LB addr=0x13, mem_rd_i=0x80FF_0000 -> core_rd_o=0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH addr=0x22 wd=0x1234ABCD -> mem_be_o=1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x20.
//  4 LW addr=0x06 -> access_fault_o=1 same cycle, mem_req_o=0, stall 0; LH addr=0x05 same.
//  5 LW, mem_ready_i held 0 -> fault after TIMEOUT=16 cycles, core_rd_o=0xDEADBEEF, then IDLE.
//  6 rst_ni low in BUSY -> mem_req_o/core_stall_o 0 immediately; after release, LW addr=0 completes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// FSM state type, latched request payload and store lane/legality helpers.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NBE  = XLEN / 8;

    // funct3 access-size encodings
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_t;

    // Request captured at acceptance and replayed to memory while BUSY
    typedef struct packed {
        logic            we;
        logic [2:0]      size;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wd;
    } lsu_req_t;

    // Unsigned sizes exist only for loads; 011/110/111 never legal
    function automatic logic lsu_size_legal(input logic we, input logic [2:0] size);
        case (size)
            LDST_B, LDST_H, LDST_W: return 1'b1;
            LDST_BU, LDST_HU:       return !we;
            default:                return 1'b0;
        endcase
    endfunction

    // Natural alignment check on the low address bits
    function automatic logic lsu_aligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_H, LDST_HU: return !off[0];
            LDST_W:          return (off == 2'b00);
            default:         return 1'b1;
        endcase
    endfunction

    // Byte-lane enables for the addressed bytes
    function automatic logic [NBE-1:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 4'b0001 << off;
            LDST_H, LDST_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:         return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could occupy
    function automatic logic [XLEN-1:0] lsu_wdata(input logic [2:0] size, input logic [XLEN-1:0] wd);
        case (size)
            LDST_B, LDST_BU: return {4{wd[7:0]}};
            LDST_H, LDST_HU: return {2{wd[15:0]}};
            default:         return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects the addressed byte/half lane from a memory
// word and sign- or zero-extends it to 32 bits.
//   rd_word_i  in  32  raw memory word
//   offset_i   in  2   byte offset within the word
//   size_i     in  3   funct3 access size
//   result_o   out 32  extended load result
module lsu_load_ext
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rd_word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      size_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rd_word_i[7:0];
            2'd1:    byte_sel = rd_word_i[15:8];
            2'd2:    byte_sel = rd_word_i[23:16];
            default: byte_sel = rd_word_i[31:24];
        endcase
        half_sel = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    end

    // Extension
    always_comb begin
        case (size_i)
            LDST_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: result_o = {24'd0, byte_sel};
            LDST_H:  result_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: result_o = {16'd0, half_sel};
            default: result_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator between the core MEM stage and data memory.
// Converts byte/half/word requests into word-addressed memory accesses with
// byte enables, stalls the core until the response, extends load data and
// flags misaligned, illegal-size and timed-out accesses.
//   clk_i, rst_ni                 clock, async active-low reset
//   core_req_i/we_i/size_i        core access request, direction, funct3 size
//   core_addr_i, core_wd_i        byte address, right-aligned store data
//   core_rd_o                     extended load data in completion cycle
//   core_stall_o                  hold core while access outstanding
//   access_fault_o                one-cycle fault pulse
//   mem_req_o/we_o/be_o/addr_o/wd_o  word-addressed memory request
//   mem_rd_i, mem_ready_i         memory read data, response valid
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [2:0]      core_size_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wd_i,
    output logic [XLEN-1:0] core_rd_o,
    output logic            core_stall_o,
    output logic            access_fault_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [NBE-1:0]  mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wd_o,
    input  logic [XLEN-1:0] mem_rd_i,
    input  logic            mem_ready_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [XLEN-1:0] TIMEOUT_DATA = 32'hdead_beef;

    lsu_state_t       state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            req_ok;
    logic            timeout_hit;
    logic [XLEN-1:0] load_res;

    // Ungated output values
    logic [XLEN-1:0] core_rd_c;
    logic            core_stall_c;
    logic            access_fault_c;
    logic            mem_req_c;
    logic            mem_we_c;
    logic [NBE-1:0]  mem_be_c;
    logic [XLEN-1:0] mem_addr_c;
    logic [XLEN-1:0] mem_wd_c;

    assign req_ok      = lsu_size_legal(core_we_i, core_size_i)
                      && lsu_aligned(core_size_i, core_addr_i[1:0]);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_load_ext u_load_ext (
        .rd_word_i (mem_rd_i),
        .offset_i  (req_q.addr[1:0]),
        .size_i    (req_q.size),
        .result_o  (load_res)
    );

    // State, latched request and timeout counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and memory/core handshake
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        cnt_d          = cnt_q;
        core_rd_c      = '0;
        core_stall_c   = 1'b0;
        access_fault_c = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_be_c       = '0;
        mem_addr_c     = '0;
        mem_wd_c       = '0;

        case (state_q)
            LSU_IDLE: begin
                if (core_req_i) begin
                    if (req_ok) begin
                        // Issue straight from the core so a 1-cycle memory completes in 2
                        mem_req_c    = 1'b1;
                        mem_we_c     = core_we_i;
                        mem_be_c     = lsu_be(core_size_i, core_addr_i[1:0]);
                        mem_addr_c   = {core_addr_i[XLEN-1:2], 2'b00};
                        mem_wd_c     = lsu_wdata(core_size_i, core_wd_i);
                        core_stall_c = 1'b1;
                        req_d.we     = core_we_i;
                        req_d.size   = core_size_i;
                        req_d.addr   = core_addr_i;
                        req_d.wd     = core_wd_i;
                        cnt_d        = '0;
                        state_d      = LSU_BUSY;
                    end else begin
                        access_fault_c = 1'b1;
                    end
                end
            end

            LSU_BUSY: begin
                mem_req_c  = 1'b1;
                mem_we_c   = req_q.we;
                mem_be_c   = lsu_be(req_q.size, req_q.addr[1:0]);
                mem_addr_c = {req_q.addr[XLEN-1:2], 2'b00};
                mem_wd_c   = lsu_wdata(req_q.size, req_q.wd);
                if (mem_ready_i) begin
                    // A response on the last allowed cycle wins over the timeout
                    core_rd_c = req_q.we ? '0 : load_res;
                    state_d   = LSU_IDLE;
                end else if (timeout_hit) begin
                    access_fault_c = 1'b1;
                    core_rd_c      = TIMEOUT_DATA;
                    state_d        = LSU_IDLE;
                end else begin
                    core_stall_c = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = LSU_IDLE;
        endcase
    end

    // Force all outputs low for the whole reset window, whatever the core drives
    assign core_rd_o      = rst_ni ? core_rd_c : '0;
    assign core_stall_o   = rst_ni & core_stall_c;
    assign access_fault_o = rst_ni & access_fault_c;
    assign mem_req_o      = rst_ni & mem_req_c;
    assign mem_we_o       = rst_ni & mem_we_c;
    assign mem_be_o       = rst_ni ? mem_be_c : '0;
    assign mem_addr_o     = rst_ni ? mem_addr_c : '0;
    assign mem_wd_o       = rst_ni ? mem_wd_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected memory
// requests and core responses per access; a negedge monitor compares.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        access_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        fault;
        bit          chk_rd;
        int          cyc;
        bit          has_mem;
    } rsp_t;

    mem_t mq[$];
    rsp_t rq[$];

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .core_req_i     (core_req_i),
        .core_we_i      (core_we_i),
        .core_size_i    (core_size_i),
        .core_addr_i    (core_addr_i),
        .core_wd_i      (core_wd_i),
        .core_rd_o      (core_rd_o),
        .core_stall_o   (core_stall_o),
        .access_fault_o (access_fault_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i),
        .mem_ready_i    (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s op%0d: actual=%h required=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against queued expectations
    initial begin : monitor
        int cyc;
        rsp_t r;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                cyc = 0;
            end else if (!core_req_i) begin
                check("idle_mem_req", -1, 32'(mem_req_o), 32'd0);
                check("idle_stall", -1, 32'(core_stall_o), 32'd0);
                check("idle_fault", -1, 32'(access_fault_o), 32'd0);
                check("idle_rd", -1, core_rd_o, 32'd0);
            end else begin
                cyc++;
                if (rq.size() == 0) begin
                    check("rsp_unexpected_req", -1, 32'(core_stall_o | mem_req_o), 32'd0);
                end else begin
                    r = rq[0];
                    check("mem_req", r.id, 32'(mem_req_o), 32'(r.has_mem));
                    if (mem_req_o && mq.size() > 0) begin
                        check("mem_we", mq[0].id, 32'(mem_we_o), 32'(mq[0].we));
                        check("mem_addr", mq[0].id, mem_addr_o, mq[0].addr);
                        if (mq[0].we) begin
                            check("mem_be", mq[0].id, 32'(mem_be_o), 32'(mq[0].be));
                            check("mem_wd", mq[0].id, mem_wd_o, mq[0].wd);
                        end
                    end
                    if (core_stall_o) begin
                        check("stall_rd", r.id, core_rd_o, 32'd0);
                        check("stall_fault", r.id, 32'(access_fault_o), 32'd0);
                    end else begin
                        void'(rq.pop_front());
                        if (r.chk_rd) check("core_rd", r.id, core_rd_o, r.rd);
                        check("fault", r.id, 32'(access_fault_o), 32'(r.fault));
                        check("cycles", r.id, 32'(cyc), 32'(r.cyc));
                        if (r.has_mem && mq.size() > 0) void'(mq.pop_front());
                        cyc = 0;
                    end
                end
            end
        end
    end

    // One core access; the memory model answers lat cycles after the request cycle
    task automatic do_op(input int id, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int lat, input bit scramble,
                         input logic [3:0] e_be, input logic [31:0] e_addr,
                         input logic [31:0] e_wd, input logic [31:0] e_rd,
                         input logic e_fault, input int e_cyc,
                         input bit has_mem, input bit chk_rd);
        int k;
        if (has_mem) mq.push_back('{id: id, we: we, be: e_be, addr: e_addr, wd: e_wd});
        rq.push_back('{id: id, rd: e_rd, fault: e_fault, chk_rd: chk_rd, cyc: e_cyc, has_mem: has_mem});
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        k = 0;
        mem_ready_i = (lat == 0);
        mem_rd_i    = (lat == 0) ? rdata : 32'h5a5a_5a5a;
        forever begin
            #1;
            if (!core_stall_o) break;
            if (k >= 40) begin
                n_chk++;
                n_fail++;
                $display("FAIL stall_bound op%0d: still stalled after %0d cycles, required completion", id, k);
                break;
            end
            @(posedge clk_i); #1;
            k++;
            if (scramble) begin
                core_addr_i = ~addr;
                core_wd_i   = ~wd;
            end
            mem_ready_i = (k >= lat);
            mem_rd_i    = (k >= lat) ? rdata : 32'h5a5a_5a5a;
        end
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h5a5a_5a5a;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst_ni      = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = '0;
        core_wd_i   = '0;
        mem_rd_i    = 32'h5a5a_5a5a;
        mem_ready_i = 1'b0;
        #2;
        check("reset_mem_req", 0, 32'(mem_req_o), 32'd0);
        check("reset_stall", 0, 32'(core_stall_o), 32'd0);
        check("reset_fault", 0, 32'(access_fault_o), 32'd0);
        check("reset_rd", 0, core_rd_o, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        //     id we size    addr          wd            rdata         lat scr be       maddr         mwd           rd            flt cyc mem chk
        do_op( 1, 1, 3'b010, 32'h0000_0010, 32'hCAFE_BABE, 32'h0,        1,  0, 4'b1111, 32'h0000_0010, 32'hCAFE_BABE, 32'h0,        0,  2,  1,  1);
        do_op( 2, 0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_0000, 1,  0, 4'b0000, 32'h0000_0010, 32'h0,        32'hFFFF_FF80, 0,  2,  1,  1);
        do_op( 3, 0, 3'b100, 32'h0000_0013, 32'h0,        32'h80FF_0000, 1,  0, 4'b0000, 32'h0000_0010, 32'h0,        32'h0000_0080, 0,  2,  1,  1);
        do_op( 4, 1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h0,        2,  1, 4'b1100, 32'h0000_0020, 32'hABCD_ABCD, 32'h0,        0,  3,  1,  1);
        do_op( 5, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        1,  1,  0,  0);
        do_op( 6, 0, 3'b001, 32'h0000_0005, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        1,  1,  0,  0);
        do_op( 7, 1, 3'b100, 32'h0000_0004, 32'h0000_0011, 32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        1,  1,  0,  0);
        do_op( 8, 0, 3'b011, 32'h0000_0008, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        1,  1,  0,  0);
        do_op( 9, 0, 3'b010, 32'h0000_0030, 32'h0,        32'h1111_2222, 999, 0, 4'b0000, 32'h0000_0030, 32'h0,        32'hDEAD_BEEF, 1, 17,  1,  1);
        do_op(10, 0, 3'b010, 32'h0000_0050, 32'h0,        32'h1357_9BDF, 16, 0, 4'b0000, 32'h0000_0050, 32'h0,        32'h1357_9BDF, 0, 17,  1,  1);
        do_op(11, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1,  0, 4'b0000, 32'h0000_0000, 32'h0,        32'hFFFF_8001, 0,  2,  1,  1);
        do_op(12, 0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1,  0, 4'b0000, 32'h0000_0000, 32'h0,        32'h0000_8001, 0,  2,  1,  1);
        do_op(13, 0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_7FFF, 1,  0, 4'b0000, 32'h0000_0000, 32'h0,        32'h0000_7FFF, 0,  2,  1,  1);
        do_op(14, 0, 3'b100, 32'h0000_0011, 32'h0,        32'h0000_AB00, 3,  0, 4'b0000, 32'h0000_0010, 32'h0,        32'h0000_00AB, 0,  4,  1,  1);
        do_op(15, 1, 3'b000, 32'h0000_000E, 32'h0000_00A5, 32'h0,        1,  0, 4'b0100, 32'h0000_000C, 32'hA5A5_A5A5, 32'h0,        0,  2,  1,  1);
        do_op(16, 1, 3'b001, 32'h0000_0008, 32'hFFFF_8765, 32'h0,        1,  0, 4'b0011, 32'h0000_0008, 32'h8765_8765, 32'h0,        0,  2,  1,  1);
        do_op(17, 0, 3'b010, 32'h0000_0044, 32'h0,        32'hDEAD_C0DE, 0,  0, 4'b0000, 32'h0000_0044, 32'h0,        32'hDEAD_C0DE, 0,  2,  1,  1);

        // A memory response with no access outstanding must be ignored
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h7777_7777;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h5a5a_5a5a;

        // Reset in the middle of an outstanding load abandons it
        mq.push_back('{id: 18, we: 1'b0, be: 4'b1111, addr: 32'h0000_0040, wd: 32'h0});
        rq.push_back('{id: 18, rd: 32'h0, fault: 1'b0, chk_rd: 1'b0, cyc: 0, has_mem: 1'b1});
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'b010;
        core_addr_i = 32'h0000_0040;
        repeat (3) @(posedge clk_i);
        #1;
        check("pre_rst_stall", 18, 32'(core_stall_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_mem_req", 18, 32'(mem_req_o), 32'd0);
        check("rst_stall", 18, 32'(core_stall_o), 32'd0);
        core_req_i = 1'b0;
        mq.delete();
        rq.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        do_op(19, 0, 3'b010, 32'h0000_0000, 32'h0,        32'h0123_4567, 1,  0, 4'b0000, 32'h0000_0000, 32'h0,        32'h0123_4567, 0,  2,  1,  1);

        repeat (3) @(posedge clk_i);
        #1;
        check("rsp_queue_drained", 0, 32'(rq.size()), 32'd0);
        check("mem_queue_drained", 0, 32'(mq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
